// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/grant/response, decode handshake
// and branch redirect from the immediate extender.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] branch_pc;
  logic [31:0] imm_data;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_fault,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, branch_pc, imm_data
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_pc, instr_valid, fetch_fault,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, branch_pc, imm_data
  );
endinterface

// File: rtl/fetch_unit.sv
// RISC-V instruction fetch: owns the PC, keeps one imem request in flight,
// buffers returned words in a small FIFO and restarts on taken branches.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, DRAIN = 2'd2, HALT = 2'd3} state_t;

  state_t        state_r, state_s;
  logic [31:0]   pc_r, pc_s;
  logic [CW-1:0] count_r, count_s;
  logic [PW-1:0] rd_ptr_r, rd_ptr_s, wr_ptr_r, wr_ptr_s;
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   fifo_pc_r [DEPTH];
  logic          req_r, fault_r;
  logic [31:0]   addr_r;
  logic [31:0]   target_s;
  logic          granted_s, push_s, pop_s, flush_s, misaligned_s, pending_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  assign target_s     = bus.branch_pc + bus.imm_data;
  assign misaligned_s = (target_s[1:0] != 2'b00);
  assign granted_s    = req_r && bus.imem_gnt;

  assign bus.imem_req    = req_r;
  assign bus.imem_addr   = addr_r;
  assign bus.fetch_fault = fault_r;
  assign bus.instr_valid = (count_r != {CW{1'b0}});
  assign bus.instruction = fifo_data_r[rd_ptr_r];
  assign bus.instr_pc    = fifo_pc_r[rd_ptr_r];

  // Next-state, PC and FIFO bookkeeping; redirect overrides the normal flow.
  always_comb begin
    state_s   = state_r;
    pc_s      = pc_r;
    push_s    = 1'b0;
    flush_s   = 1'b0;
    pop_s     = (count_r != {CW{1'b0}}) && bus.instr_ready;
    // A request is still in flight after this cycle unless its response lands now.
    pending_s = ((state_r == FETCH) && granted_s) ||
                (((state_r == WAIT) || (state_r == DRAIN)) && !bus.imem_rvalid);
    case (state_r)
      FETCH: begin
        if (granted_s) begin
          state_s = WAIT;
          pc_s    = pc_r + 32'd4;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_s = FETCH;
          push_s  = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) begin
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end
      HALT:    state_s = HALT;
      default: state_s = FETCH;
    endcase
    if (bus.redirect && (state_r != HALT)) begin
      flush_s = 1'b1;
      push_s  = 1'b0;
      if (misaligned_s) begin
        state_s = HALT;
        pc_s    = pc_r;
      end else begin
        pc_s    = target_s;
        state_s = pending_s ? DRAIN : FETCH;
      end
    end else begin
      flush_s = 1'b0;
    end
    if (flush_s) begin
      count_s  = {CW{1'b0}};
      rd_ptr_s = {PW{1'b0}};
      wr_ptr_s = {PW{1'b0}};
    end else begin
      count_s  = count_r + CW'(push_s) - CW'(pop_s);
      rd_ptr_s = pop_s  ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      wr_ptr_s = push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
    end
  end

  // State, FIFO storage and registered request/fault outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= FETCH;
      pc_r     <= RESET_PC;
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      req_r    <= 1'b0;
      addr_r   <= RESET_PC;
      fault_r  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_r[i] <= NOP;
        fifo_pc_r[i]   <= 32'h0000_0000;
      end
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      count_r  <= count_s;
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
      req_r    <= (state_s == FETCH) && (count_s < FULL);
      addr_r   <= pc_s;
      fault_r  <= (state_s == HALT);
      // pc_r already advanced past the in-flight word at grant time.
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= bus.imem_rdata;
        fifo_pc_r[wr_ptr_r]   <= pc_r - 32'd4;
      end
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core. It owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake, with at most one request outstanding. Returned words go into a small FIFO. The FIFO presents `instruction`, and its PC, to decode and to the immediate extender. On a taken branch it computes `branch_pc + imm_data` from the extender's output, flushes the FIFO and restarts fetch at that target.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `DEPTH`, 2, instruction FIFO entries (2..8).
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; all state cleared immediately on assertion.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_gnt` in 1: memory accepts the request in any cycle where `imem_req && imem_gnt`.
- `imem_rvalid` in 1: response valid, in order, at least 1 cycle after grant.
- `imem_rdata` in 32: fetched instruction word.
- `instruction` out 32: head-of-FIFO instruction, routed to decode and immediate extender.
- `instr_pc` out 32: PC of `instruction`.
- `instr_valid` out 1: FIFO not empty.
- `instr_ready` in 1: decode consumes the head when `instr_valid && instr_ready`.
- `redirect` in 1: taken branch/jump this cycle.
- `branch_pc` in 32: PC of the redirecting instruction.
- `imm_data` in 32: sign-extended offset from the immediate extender.
- `fetch_fault` out 1: sticky misaligned-target flag.

## Operation
- Target = `branch_pc + imm_data`, mod 2^32, no overflow detection.
- Sequential PC: after each grant, `pc <= pc + 4`; 32'hFFFF_FFFC wraps to 0.
- State machine:
  - FETCH: `imem_req = (count + 0) < DEPTH`, with no request outstanding. Grant moves to WAIT.
  - WAIT: one request outstanding; `imem_req = 0`. `imem_rvalid` writes {pc, rdata} into the FIFO and returns to FETCH.
  - DRAIN: stale request outstanding after a redirect. The next `imem_rvalid` is discarded, then the state goes to FETCH.
  - HALT: entered on a misaligned target. `imem_req = 0` and `fetch_fault = 1` until reset.
- Redirect in any non-HALT state:
  - FIFO flushed; `pc <=` target.
  - From WAIT, or FETCH with grant that cycle, go to DRAIN. Otherwise go to FETCH.
  - An `imem_rvalid` arriving in the redirect cycle is dropped and counts as the drained response, so the state goes to FETCH.
- Misaligned target: target[1:0] != 0 with `redirect` enters HALT. FIFO is flushed, `pc` unchanged, and any outstanding response is discarded on arrival.
- Simultaneous events:
  - A consume in the redirect cycle is a valid transfer; the remaining entries are flushed.
  - A consume and an rvalid write in the same cycle with the FIFO full are legal. Count is unchanged.
  - `redirect` in HALT is ignored.
- FIFO: circular, pointers wrap modulo DEPTH. The space check counts the outstanding request, so the FIFO never overflows.

## Timing
- Reset values:
  - `imem_req` = 0 while reset is high; `imem_addr` = RESET_PC.
  - `instr_valid` = 0, `instruction` = 32'h0000_0013 (NOP), `instr_pc` = 0, `fetch_fault` = 0. State = FETCH, count = 0.
- First `imem_req` = 1 in the first cycle after reset deasserts, at RESET_PC.
- Grant at cycle t, rvalid at t+k: `instr_valid` rises at t+k+1.
- The next request is asserted at t+k+1 (FETCH). Peak throughput is one instruction per 2 cycles with k = 1.
- Redirect at cycle t with nothing outstanding: `imem_req` = 1 with `imem_addr` = target at t+1.
- Redirect at cycle t, then in FIFO/`instr_valid` = 0 from t+1.
- `fetch_fault` goes high at t+1 after a misaligned redirect at t.
- Reset mid-operation (any state, including DRAIN): all outputs return to reset values asynchronously. A late `imem_rvalid` after reset release with nothing outstanding is ignored.

## Test plan
- Reset release, `imem_gnt` = 1, response k = 1 with rdata = 32'h0000_0093 → address sequence 0, 4, 8. `instr_pc` values 0, 4, 8 each appear with `instr_valid`.
- `instr_ready` held 0 with DEPTH = 2 → exactly 2 grants, then `imem_req` stays 0. Asserting ready re-enables the request within 1 cycle.
- Redirect with `branch_pc` = 32'h100 and `imm_data` = 32'hFFFF_FFF8 while in WAIT → the old response is dropped. The next request address is 32'h0F8 and the FIFO is empty in between.
- Redirect in the same cycle as `imem_rvalid` → the word is dropped, state is FETCH, and the next request is at the target.
- `branch_pc` = 32'h200, `imm_data` = 32'h6 → `fetch_fault` = 1, no further `imem_req`. Reset clears it.
- PC at 32'hFFFF_FFFC granted → next `imem_addr` = 0.
- Assert reset in DRAIN → outputs return to reset values immediately and fetch restarts at RESET_PC.
